// File: rtl/alu_pkg.sv
// Shared ALU opcodes, funct3 codes, issue FSM states and the funct3/funct7 decode
// used by both the issue controller and the decode stage.
package alu_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b100;
  localparam logic [2:0] ALU_OR  = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b111;
  localparam logic [2:0] ALU_NOP = 3'b001;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;

  typedef struct packed {
    logic       illegal;
    logic [2:0] opcode;
  } decode_t;

  // Bit 30 only selects SUB for register-register ops; OP-IMM ignores it.
  function automatic decode_t decode_op(input logic [2:0] funct3,
                                        input logic       funct7_5,
                                        input logic       is_imm);
    decode_t d;
    d.illegal = 1'b0;
    d.opcode  = ALU_ADD;
    case (funct3)
      F3_ADD:  d.opcode = (!is_imm && funct7_5) ? ALU_SUB : ALU_ADD;
      F3_AND:  d.opcode = ALU_AND;
      F3_OR:   d.opcode = ALU_OR;
      default: begin
        d.illegal = 1'b1;
        d.opcode  = ALU_NOP;
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alu_issue_if.sv
// Decode-side request and writeback-side response channels of the ALU issue stage.
interface alu_issue_if;
  import alu_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_funct3;
  logic              in_funct7_5;
  logic              in_is_imm;
  logic [DATA_W-1:0] in_rs1;
  logic [DATA_W-1:0] in_rs2;
  logic [DATA_W-1:0] in_imm;
  logic [REG_W-1:0]  in_rd;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;
  logic [REG_W-1:0]  out_rd;
  logic              out_illegal;

  modport master (
    output in_valid, in_funct3, in_funct7_5, in_is_imm, in_rs1, in_rs2, in_imm, in_rd,
    input  in_ready,
    input  out_valid, out_result, out_rd, out_illegal,
    output out_ready
  );

  modport slave (
    input  in_valid, in_funct3, in_funct7_5, in_is_imm, in_rs1, in_rs2, in_imm, in_rd,
    output in_ready,
    output out_valid, out_result, out_rd, out_illegal,
    input  out_ready
  );

endinterface

// File: rtl/alu.sv
// Combinational execute-stage ALU; unsupported opcodes (including NOP) yield zero.
module alu
  import alu_pkg::*;
(
  input  logic [2:0]        opcode,
  input  logic [DATA_W-1:0] left,
  input  logic [DATA_W-1:0] right,
  output logic [DATA_W-1:0] result
);

  always_comb begin
    case (opcode)
      ALU_ADD: result = left + right;
      ALU_SUB: result = left - right;
      ALU_OR:  result = left | right;
      ALU_AND: result = left & right;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_issue.sv
// Multicycle issue controller: latches a decoded op, runs it through the ALU for one
// cycle, then holds the captured result for writeback until it is taken.
module alu_issue
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  alu_issue_if.slave        bus,
  output logic [DATA_W-1:0] op_count
);

  state_e            state_q, state_d;
  logic [2:0]        opcode_q, opcode_d;
  logic [DATA_W-1:0] left_q, left_d;
  logic [DATA_W-1:0] right_q, right_d;
  logic [REG_W-1:0]  rd_q, rd_d;
  logic              illegal_q, illegal_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [REG_W-1:0]  out_rd_q, out_rd_d;
  logic              out_illegal_q, out_illegal_d;
  logic [DATA_W-1:0] op_count_q, op_count_d;

  logic [DATA_W-1:0] alu_result;
  logic              accept;
  logic              out_fire;
  decode_t           dec;

  alu u_alu (
    .opcode (opcode_q),
    .left   (left_q),
    .right  (right_q),
    .result (alu_result)
  );

  // Held low during reset so decode never sees a ready it cannot honour.
  assign bus.in_ready = rst_n && ((state_q == IDLE) || (state_q == DONE && bus.out_ready));
  assign accept       = bus.in_valid && bus.in_ready;
  assign out_fire     = (state_q == DONE) && bus.out_ready;
  assign dec          = decode_op(bus.in_funct3, bus.in_funct7_5, bus.in_is_imm);

  // NOTE: every always_comb output gets a hold-value default first, so no path infers a latch.
  always_comb begin
    state_d       = state_q;
    opcode_d      = opcode_q;
    left_d        = left_q;
    right_d       = right_q;
    rd_d          = rd_q;
    illegal_d     = illegal_q;
    result_d      = result_q;
    out_rd_d      = out_rd_q;
    out_illegal_d = out_illegal_q;
    op_count_d    = op_count_q;

    if (out_fire) begin
      op_count_d = op_count_q + 1'b1;
      state_d    = IDLE;
    end
    if (state_q == EXEC) begin
      result_d      = alu_result;
      out_rd_d      = rd_q;
      out_illegal_d = illegal_q;
      state_d       = DONE;
    end
    if (accept) begin
      opcode_d  = dec.opcode;
      illegal_d = dec.illegal;
      left_d    = bus.in_rs1;
      right_d   = bus.in_is_imm ? bus.in_imm : bus.in_rs2;
      rd_d      = bus.in_rd;
      state_d   = EXEC;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      opcode_q      <= ALU_NOP;
      left_q        <= '0;
      right_q       <= '0;
      rd_q          <= '0;
      illegal_q     <= 1'b0;
      result_q      <= '0;
      out_rd_q      <= '0;
      out_illegal_q <= 1'b0;
      op_count_q    <= '0;
    end else begin
      state_q       <= state_d;
      opcode_q      <= opcode_d;
      left_q        <= left_d;
      right_q       <= right_d;
      rd_q          <= rd_d;
      illegal_q     <= illegal_d;
      result_q      <= result_d;
      out_rd_q      <= out_rd_d;
      out_illegal_q <= out_illegal_d;
      op_count_q    <= op_count_d;
    end
  end

  assign bus.out_valid   = (state_q == DONE);
  assign bus.out_result  = result_q;
  assign bus.out_rd      = out_rd_q;
  assign bus.out_illegal = out_illegal_q;
  assign op_count        = op_count_q;

endmodule

// File: tb/tb_alu_issue.sv
// Directed-vector bench for alu_issue: decode cases, latency, backpressure,
// back-to-back issue through DONE, and reset abort.
module tb_alu_issue;
  import alu_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [DATA_W-1:0] op_count;

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [DATA_W-1:0] exp_count = '0;

  alu_issue_if bus ();

  alu_issue dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus.slave),
    .op_count (op_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive_op(input logic [2:0] f3, input logic f7_5, input logic is_imm,
                          input logic [31:0] rs1, input logic [31:0] rs2,
                          input logic [31:0] imm, input logic [4:0] rd);
    bus.in_valid    = 1'b1;
    bus.in_funct3   = f3;
    bus.in_funct7_5 = f7_5;
    bus.in_is_imm   = is_imm;
    bus.in_rs1      = rs1;
    bus.in_rs2      = rs2;
    bus.in_imm      = imm;
    bus.in_rd       = rd;
  endtask

  // Accept in IDLE, check latency and result, then complete the out handshake.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic f7_5,
                        input logic is_imm, input logic [31:0] rs1, input logic [31:0] rs2,
                        input logic [31:0] imm, input logic [4:0] rd,
                        input logic [31:0] exp_res, input logic exp_ill);
    @(negedge clk);
    drive_op(f3, f7_5, is_imm, rs1, rs2, imm, rd);
    #1 check({tag, " in_ready idle"}, 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_rs1   = '1;
    check({tag, " no valid in exec"}, 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;
    check({tag, " out_valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, " result"}, bus.out_result, exp_res);
    check({tag, " rd"}, 32'(bus.out_rd), 32'(rd));
    check({tag, " illegal"}, 32'(bus.out_illegal), 32'(exp_ill));
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    exp_count = exp_count + 1;
    check({tag, " op_count"}, op_count, exp_count);
    check({tag, " back to idle"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] held_res;
    rst_n         = 1'b0;
    bus.out_ready = 1'b0;
    drive_op(3'b000, 1'b0, 1'b0, '0, '0, '0, '0);
    bus.in_valid  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset in_ready", 32'(bus.in_ready), 32'd0);
    check("reset out_valid", 32'(bus.out_valid), 32'd0);
    check("reset out_result", bus.out_result, 32'd0);
    check("reset out_rd", 32'(bus.out_rd), 32'd0);
    check("reset out_illegal", 32'(bus.out_illegal), 32'd0);
    check("reset op_count", op_count, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("in_ready after reset", 32'(bus.in_ready), 32'd1);

    run_op("add",  3'b000, 1'b0, 1'b0, 32'd5, 32'd7, 32'd0, 5'd3, 32'd12, 1'b0);
    run_op("sub",  3'b000, 1'b1, 1'b0, 32'd0, 32'd1, 32'd0, 5'd4, 32'hFFFF_FFFF, 1'b0);
    run_op("addi", 3'b000, 1'b1, 1'b1, 32'd0, 32'd1, 32'd1, 5'd5, 32'd1, 1'b0);
    run_op("and",  3'b111, 1'b0, 1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'd0, 5'd6,
           32'h00F0_00F0, 1'b0);
    run_op("or",   3'b110, 1'b0, 1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'd0, 5'd7,
           32'hFFF0_FFF0, 1'b0);
    run_op("andi", 3'b111, 1'b0, 1'b1, 32'hF0F0_F0F0, 32'hFFFF_FFFF, 32'h0000_FF00, 5'd8,
           32'h0000_F000, 1'b0);
    run_op("illegal", 3'b100, 1'b0, 1'b0, 32'h0000_FFFF, 32'h0000_FFFF, 32'd0, 5'd9,
           32'd0, 1'b1);

    // Backpressure: first op parks in DONE while a second op is offered.
    @(negedge clk);
    drive_op(3'b000, 1'b0, 1'b0, 32'd100, 32'd23, 32'd0, 5'd10);
    @(posedge clk); #1;
    drive_op(3'b000, 1'b1, 1'b0, 32'd50, 32'd8, 32'd0, 5'd11);
    @(posedge clk); #1;
    check("bp out_valid", 32'(bus.out_valid), 32'd1);
    check("bp result", bus.out_result, 32'd123);
    held_res = bus.out_result;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp stall valid", 32'(bus.out_valid), 32'd1);
      check("bp stall result", bus.out_result, held_res);
      check("bp stall rd", 32'(bus.out_rd), 32'd10);
      check("bp stall in_ready", 32'(bus.in_ready), 32'd0);
    end
    check("bp op_count held", op_count, exp_count);
    @(negedge clk);
    bus.out_ready = 1'b1;
    #1 check("b2b in_ready follows out_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    exp_count = exp_count + 1;
    check("b2b op_count", op_count, exp_count);
    check("b2b exec no valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;
    check("b2b out_valid", 32'(bus.out_valid), 32'd1);
    check("b2b result", bus.out_result, 32'd42);
    check("b2b rd", 32'(bus.out_rd), 32'd11);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    exp_count = exp_count + 1;
    check("b2b second op_count", op_count, exp_count);

    // Reset while the op is in EXEC: it must vanish.
    @(negedge clk);
    drive_op(3'b000, 1'b0, 1'b0, 32'd1, 32'd2, 32'd0, 5'd12);
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    rst_n = 1'b0;
    #1 check("rst in_ready low", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    check("rst out_valid", 32'(bus.out_valid), 32'd0);
    check("rst op_count", op_count, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst in_ready after release", 32'(bus.in_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      check("rst no emit", 32'(bus.out_valid), 32'd0);
      @(posedge clk); #1;
    end
    check("rst op_count stays", op_count, 32'd0);
    bus.out_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
